// File: rtl/riscv_pkg.sv
// Shared opcode/funct3 constants, ALU operation and stage state types for the RV32I execute stage.
// Feature macro: RISCV_EXU_BRANCH_EN (branch/jump execution and fetch redirect).
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef enum logic {RUN, FLUSH} exu_state_e;

  // alt selects SUB for funct3=ADD and SRA for funct3=SR.
  function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:    return a + b;
      ALU_SUB:    return a - b;
      ALU_SLL:    return a << b[4:0];
      ALU_SLT:    return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:   return {31'b0, a < b};
      ALU_XOR:    return a ^ b;
      ALU_SRL:    return a >> b[4:0];
      ALU_SRA:    return $signed(a) >>> b[4:0];
      ALU_OR:     return a | b;
      ALU_AND:    return a & b;
      ALU_PASS_B: return b;
      default:    return '0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_exu_if.sv
// Register file access bundle: two combinational read ports and one write port.
// Feature macro: RISCV_EXU_BRANCH_EN (not used in this file).
interface riscv_exu_if;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  modport master (output rs1_addr, rs2_addr, we, waddr, wdata, input rs1_data, rs2_data);
  modport slave  (input rs1_addr, rs2_addr, we, waddr, wdata, output rs1_data, rs2_data);
endinterface

// File: rtl/riscv_regfile.sv
// 31x32 integer register file; x0 reads as zero and is never stored.
// Feature macro: RISCV_EXU_BRANCH_EN (not used in this file).
module riscv_regfile (
  input logic        clock,
  input logic        reset,
  riscv_exu_if.slave rf
);

  logic [31:0] r_regs [32];

  // NOTE: this array is reset because x1-x31 must read zero after reset; large RAMs normally are not.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) r_regs[i] <= '0;
    end else if (rf.we && rf.waddr != 5'd0) begin
      r_regs[rf.waddr] <= rf.wdata;
    end
  end

  assign rf.rs1_data = (rf.rs1_addr == 5'd0) ? 32'h0 : r_regs[rf.rs1_addr];
  assign rf.rs2_data = (rf.rs2_addr == 5'd0) ? 32'h0 : r_regs[rf.rs2_addr];

endmodule

// File: rtl/riscv_exu.sv
// RV32I execute/writeback stage: decode, ALU, branch resolve, registered completion and redirect.
// Feature macro: RISCV_EXU_BRANCH_EN enables BRANCH/JAL/JALR, the FLUSH state and redirects.
module riscv_exu
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        idu_vld,
  input  logic [31:0] idu_addr,
  input  logic [31:0] idu_data,
  output logic        exu_vld,
  output logic [31:0] exu_addr,
  output logic [4:0]  exu_rd,
  output logic        exu_we,
  output logic [31:0] exu_wdata,
  output logic        exu_illegal,
  output logic        redir_vld,
  output logic [31:0] redir_addr
);

  if (RESET_ADDR[1:0] != 2'b00) begin : g_bad_reset_addr
    $error("RESET_ADDR must be word aligned");
  end

  logic [6:0]  w_opc;
  logic [4:0]  w_rd;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_u;
  logic        w_legal, w_writes, w_illegal, w_we, w_accept;
  alu_op_e     w_op;
  logic [31:0] w_a, w_b, w_result;

  logic        r_exu_vld, r_exu_we, r_exu_illegal;
  logic [31:0] r_exu_addr, r_exu_wdata;
  logic [4:0]  r_exu_rd;

  riscv_exu_if w_rf ();
  riscv_regfile u_regfile (.clock(clock), .reset(reset), .rf(w_rf));

  assign w_opc   = idu_data[6:0];
  assign w_rd    = idu_data[11:7];
  assign w_f3    = idu_data[14:12];
  assign w_f7    = idu_data[31:25];
  assign w_imm_i = {{20{idu_data[31]}}, idu_data[31:20]};
  assign w_imm_u = {idu_data[31:12], 12'b0};

  assign w_rf.rs1_addr = idu_data[19:15];
  assign w_rf.rs2_addr = idu_data[24:20];

`ifdef RISCV_EXU_BRANCH_EN
  logic [31:0] w_imm_b, w_imm_j, w_target;
  logic        w_jump, w_branch, w_cond, w_taken, w_redir;
  exu_state_e  r_state;
  logic [31:0] r_target;
  logic        r_redir_vld;
  logic [31:0] r_redir_addr;

  assign w_imm_b = {{19{idu_data[31]}}, idu_data[31], idu_data[7], idu_data[30:25], idu_data[11:8], 1'b0};
  assign w_imm_j = {{11{idu_data[31]}}, idu_data[31], idu_data[19:12], idu_data[20], idu_data[30:21], 1'b0};
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_legal  = 1'b0;
    w_writes = 1'b0;
    w_op     = ALU_ADD;
    w_a      = w_rf.rs1_data;
    w_b      = w_imm_i;
`ifdef RISCV_EXU_BRANCH_EN
    w_jump   = 1'b0;
    w_branch = 1'b0;
    w_target = '0;
`endif
    case (w_opc)
      OPC_LUI: begin
        w_legal = 1'b1; w_writes = 1'b1; w_op = ALU_PASS_B; w_b = w_imm_u;
      end
      OPC_AUIPC: begin
        w_legal = 1'b1; w_writes = 1'b1; w_a = idu_addr; w_b = w_imm_u;
      end
      OPC_OP_IMM: begin
        w_writes = 1'b1;
        w_op     = f3_to_alu(w_f3, idu_data[30] && w_f3 == F3_SR);
        if (w_f3 == F3_SLL)     w_legal = (w_f7 == F7_BASE);
        else if (w_f3 == F3_SR) w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
        else                    w_legal = 1'b1;
      end
      OPC_OP: begin
        w_writes = 1'b1;
        w_b      = w_rf.rs2_data;
        w_op     = f3_to_alu(w_f3, idu_data[30]);
        w_legal  = (w_f7 == F7_BASE) || (w_f7 == F7_ALT && (w_f3 == F3_ADD || w_f3 == F3_SR));
      end
`ifdef RISCV_EXU_BRANCH_EN
      // Jumps reuse the adder for the link value pc+4.
      OPC_JAL: begin
        w_legal = 1'b1; w_writes = 1'b1; w_jump = 1'b1;
        w_a = idu_addr; w_b = 32'd4;
        w_target = idu_addr + w_imm_j;
      end
      OPC_JALR: begin
        w_legal = (w_f3 == 3'd0); w_writes = 1'b1; w_jump = 1'b1;
        w_a = idu_addr; w_b = 32'd4;
        w_target = (w_rf.rs1_data + w_imm_i) & ~32'd1;
      end
      OPC_BRANCH: begin
        w_legal  = (w_f3 != 3'd2) && (w_f3 != 3'd3);
        w_branch = 1'b1;
        w_target = idu_addr + w_imm_b;
      end
`endif
      default: ;
    endcase
  end

  assign w_result = alu(w_op, w_a, w_b);

`ifdef RISCV_EXU_BRANCH_EN
  always_comb begin
    case (w_f3)
      F3_BEQ:  w_cond = (w_rf.rs1_data == w_rf.rs2_data);
      F3_BNE:  w_cond = (w_rf.rs1_data != w_rf.rs2_data);
      F3_BLT:  w_cond = ($signed(w_rf.rs1_data) <  $signed(w_rf.rs2_data));
      F3_BGE:  w_cond = ($signed(w_rf.rs1_data) >= $signed(w_rf.rs2_data));
      F3_BLTU: w_cond = (w_rf.rs1_data <  w_rf.rs2_data);
      F3_BGEU: w_cond = (w_rf.rs1_data >= w_rf.rs2_data);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken   = w_jump || (w_branch && w_cond);
  assign w_illegal = !w_legal || (w_taken && w_target[1]);
  assign w_redir   = !w_illegal && w_taken;
  // While flushing, only the instruction at the saved target is executed.
  assign w_accept  = idu_vld && (r_state == RUN || idu_addr == r_target);
`else
  assign w_illegal = !w_legal;
  assign w_accept  = idu_vld;
`endif

  assign w_we         = !w_illegal && w_writes && (w_rd != 5'd0);
  assign w_rf.we      = w_accept && w_we;
  assign w_rf.waddr   = w_rd;
  assign w_rf.wdata   = w_result;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_exu_vld     <= 1'b0;
      r_exu_addr    <= '0;
      r_exu_rd      <= '0;
      r_exu_we      <= 1'b0;
      r_exu_wdata   <= '0;
      r_exu_illegal <= 1'b0;
`ifdef RISCV_EXU_BRANCH_EN
      r_state       <= RUN;
      r_target      <= '0;
      r_redir_vld   <= 1'b0;
      r_redir_addr  <= '0;
`endif
    end else begin
      r_exu_vld <= w_accept;
      if (w_accept) begin
        r_exu_addr    <= idu_addr;
        r_exu_rd      <= w_writes ? w_rd : 5'd0;
        r_exu_we      <= w_we;
        r_exu_wdata   <= w_we ? w_result : 32'h0;
        r_exu_illegal <= w_illegal;
      end
`ifdef RISCV_EXU_BRANCH_EN
      r_redir_vld <= w_accept && w_redir;
      if (w_accept) begin
        r_redir_addr <= w_redir ? w_target : 32'h0;
        r_state      <= w_redir ? FLUSH : RUN;
        if (w_redir) r_target <= w_target;
      end
`endif
    end
  end

  assign exu_vld     = r_exu_vld;
  assign exu_addr    = r_exu_addr;
  assign exu_rd      = r_exu_rd;
  assign exu_we      = r_exu_we;
  assign exu_wdata   = r_exu_wdata;
  assign exu_illegal = r_exu_illegal;
`ifdef RISCV_EXU_BRANCH_EN
  assign redir_vld   = r_redir_vld;
  assign redir_addr  = r_redir_addr;
`else
  assign redir_vld   = 1'b0;
  assign redir_addr  = 32'h0;
`endif

endmodule

// File: tb/tb_riscv_exu.sv
// Scoreboard bench for riscv_exu: expectations are queued at issue and checked on exu_vld.
// Covers both builds of RISCV_EXU_BRANCH_EN.
module tb_riscv_exu;
  import riscv_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] wdata;
    logic        illegal;
    logic        redir;
    logic [31:0] raddr;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        idu_vld = 1'b0;
  logic [31:0] idu_addr = '0;
  logic [31:0] idu_data = '0;
  logic        exu_vld, exu_we, exu_illegal, redir_vld;
  logic [31:0] exu_addr, exu_wdata, redir_addr;
  logic [4:0]  exu_rd;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  riscv_exu #(.RESET_ADDR(32'h0)) dut (
    .clock(clock), .reset(reset),
    .idu_vld(idu_vld), .idu_addr(idu_addr), .idu_data(idu_data),
    .exu_vld(exu_vld), .exu_addr(exu_addr), .exu_rd(exu_rd), .exu_we(exu_we),
    .exu_wdata(exu_wdata), .exu_illegal(exu_illegal),
    .redir_vld(redir_vld), .redir_addr(redir_addr)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

  function automatic exp_t exp_w(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] v);
    return {pc, rd, rd != 5'd0, (rd != 5'd0) ? v : 32'h0, 1'b0, 1'b0, 32'h0};
  endfunction
  function automatic exp_t exp_ill(input logic [31:0] pc, input logic [4:0] rd);
    return {pc, rd, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0};
  endfunction
  function automatic exp_t exp_br(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    return {pc, 5'd0, 1'b0, 32'h0, 1'b0, taken, taken ? tgt : 32'h0};
  endfunction
  function automatic exp_t exp_jmp(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] tgt);
    return {pc, rd, rd != 5'd0, (rd != 5'd0) ? pc + 32'd4 : 32'h0, 1'b0, 1'b1, tgt};
  endfunction

  task automatic exec(input logic [31:0] pc, input logic [31:0] ins, input exp_t e);
    @(negedge clock);
    q.push_back(e);
    idu_vld = 1'b1; idu_addr = pc; idu_data = ins;
  endtask

  task automatic drop(input logic [31:0] pc, input logic [31:0] ins);
    @(negedge clock);
    idu_vld = 1'b1; idu_addr = pc; idu_data = ins;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    @(negedge clock);
    idu_vld = 1'b0;
    while (q.size() != 0 && k < 20) begin
      @(negedge clock);
      k++;
    end
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d outputs missing, required 0", tag, q.size());
      q.delete();
    end
  endtask

  // Scoreboard: every completion must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t act, e;
    if (!reset && (exu_vld || redir_vld)) begin
      act = {exu_addr, exu_rd, exu_we, exu_wdata, exu_illegal, redir_vld, redir_addr};
      n_vec++;
      if (!exu_vld) begin
        n_err++;
        $display("FAIL redir_without_vld: redir_addr=%h, required no redirect", redir_addr);
      end else if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: pc=%h rd=%0d, required none", exu_addr, exu_rd);
      end else begin
        e = q.pop_front();
        if (act !== e) begin
          n_err++;
          $display("FAIL completion_pc%h: got pc=%h rd=%0d we=%b wdata=%h ill=%b redir=%b/%h, required pc=%h rd=%0d we=%b wdata=%h ill=%b redir=%b/%h",
                   e.addr, act.addr, act.rd, act.we, act.wdata, act.illegal, act.redir, act.raddr,
                   e.addr, e.rd, e.we, e.wdata, e.illegal, e.redir, e.raddr);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    logic [104:0] outs;
    outs = {exu_vld, exu_addr, exu_rd, exu_we, exu_wdata, exu_illegal, redir_vld, redir_addr};
    n_vec++;
    if (outs !== '0) begin
      n_err++;
      $display("FAIL %s: outputs=%h, required all zero", tag, outs);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_zero("reset_outputs");
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    exec(32'h00, enc_i(12'd5, 5'd0, F3_ADD, 5'd1, OPC_OP_IMM), exp_w(32'h00, 5'd1, 32'd5));
    exec(32'h04, enc_r(F7_BASE, 5'd1, 5'd1, F3_ADD, 5'd2),     exp_w(32'h04, 5'd2, 32'd10));
    drain("back_to_back");
  endtask

  task automatic test_alu();
    exec(32'h08, enc_u(20'h80000, 5'd3, OPC_LUI),                 exp_w(32'h08, 5'd3, 32'h8000_0000));
    exec(32'h0C, enc_i(12'h404, 5'd3, F3_SR, 5'd4, OPC_OP_IMM),   exp_w(32'h0C, 5'd4, 32'hF800_0000));
    exec(32'h10, enc_i(12'h004, 5'd3, F3_SR, 5'd4, OPC_OP_IMM),   exp_w(32'h10, 5'd4, 32'h0800_0000));
    exec(32'h14, enc_i(12'd7, 5'd0, F3_ADD, 5'd0, OPC_OP_IMM),    exp_w(32'h14, 5'd0, 32'h0));
    exec(32'h18, enc_r(F7_BASE, 5'd0, 5'd0, F3_ADD, 5'd5),        exp_w(32'h18, 5'd5, 32'h0));
    exec(32'h1C, enc_r(F7_ALT, 5'd2, 5'd1, F3_ADD, 5'd6),         exp_w(32'h1C, 5'd6, 32'hFFFF_FFFB));
    exec(32'h20, enc_r(F7_BASE, 5'd1, 5'd6, F3_SLT, 5'd7),        exp_w(32'h20, 5'd7, 32'd1));
    exec(32'h24, enc_r(F7_BASE, 5'd1, 5'd6, F3_SLTU, 5'd8),       exp_w(32'h24, 5'd8, 32'd0));
    exec(32'h28, enc_i(12'hFFF, 5'd1, F3_SLTU, 5'd9, OPC_OP_IMM), exp_w(32'h28, 5'd9, 32'd1));
    exec(32'h2C, enc_u(20'h12345, 5'd10, OPC_AUIPC),              exp_w(32'h2C, 5'd10, 32'h1234_502C));
    exec(32'h30, enc_i(12'h0F0, 5'd1, F3_XOR, 5'd11, OPC_OP_IMM), exp_w(32'h30, 5'd11, 32'h0000_00F5));
    exec(32'h34, enc_r(F7_BASE, 5'd2, 5'd1, F3_SLL, 5'd12),       exp_w(32'h34, 5'd12, 32'h0000_1400));
    exec(32'h38, enc_i(12'hFFF, 5'd3, F3_AND, 5'd13, OPC_OP_IMM), exp_w(32'h38, 5'd13, 32'h8000_0000));
    drain("alu");
  endtask

  task automatic test_illegal();
    exec(32'h3C, enc_i(12'd0, 5'd0, 3'd2, 5'd1, 7'b0000011),   exp_ill(32'h3C, 5'd0));
    exec(32'h40, enc_r(7'h01, 5'd2, 5'd1, F3_ADD, 5'd22),      exp_ill(32'h40, 5'd22));
    exec(32'h44, enc_i(12'd0, 5'd1, F3_ADD, 5'd14, OPC_OP_IMM), exp_w(32'h44, 5'd14, 32'd5));
    drain("illegal");
  endtask

  task automatic test_branch();
`ifdef RISCV_EXU_BRANCH_EN
    exec(32'h100, enc_b(13'd8, 5'd0, 5'd0, F3_BEQ), exp_br(32'h100, 1'b1, 32'h108));
    drop(32'h104, enc_i(12'd1, 5'd0, F3_ADD, 5'd15, OPC_OP_IMM));
    exec(32'h108, enc_i(12'd2, 5'd0, F3_ADD, 5'd15, OPC_OP_IMM),  exp_w(32'h108, 5'd15, 32'd2));
    exec(32'h10C, enc_i(12'd1, 5'd15, F3_ADD, 5'd15, OPC_OP_IMM), exp_w(32'h10C, 5'd15, 32'd3));
    exec(32'h110, enc_b(13'd8, 5'd0, 5'd0, F3_BNE), exp_br(32'h110, 1'b0, 32'h0));
    exec(32'h114, enc_j(21'd12, 5'd16),             exp_jmp(32'h114, 5'd16, 32'h120));
    drop(32'h118, enc_i(12'd1, 5'd0, F3_ADD, 5'd16, OPC_OP_IMM));
    exec(32'h120, enc_i(12'h0FD, 5'd1, 3'd0, 5'd17, OPC_JALR),    exp_ill(32'h120, 5'd17));
    exec(32'h124, enc_i(12'h1FB, 5'd1, 3'd0, 5'd18, OPC_JALR),    exp_jmp(32'h124, 5'd18, 32'h200));
    exec(32'h200, enc_b(13'h1F00, 5'd1, 5'd6, F3_BLT), exp_br(32'h200, 1'b1, 32'h100));
    drop(32'h204, enc_i(12'd1, 5'd0, F3_ADD, 5'd19, OPC_OP_IMM));
    exec(32'h100, enc_i(12'd9, 5'd0, F3_ADD, 5'd19, OPC_OP_IMM),  exp_w(32'h100, 5'd19, 32'd9));
`else
    exec(32'h100, enc_b(13'd8, 5'd0, 5'd0, F3_BEQ), exp_ill(32'h100, 5'd0));
    exec(32'h104, enc_i(12'd1, 5'd0, F3_ADD, 5'd15, OPC_OP_IMM),  exp_w(32'h104, 5'd15, 32'd1));
    exec(32'h108, enc_j(21'd12, 5'd16),             exp_ill(32'h108, 5'd0));
    exec(32'h10C, enc_i(12'h1FB, 5'd1, 3'd0, 5'd18, OPC_JALR),    exp_ill(32'h10C, 5'd0));
`endif
    drain("branch");
  endtask

  task automatic test_reset_flush();
`ifdef RISCV_EXU_BRANCH_EN
    exec(32'h104, enc_b(13'd16, 5'd0, 5'd0, F3_BEQ), exp_br(32'h104, 1'b1, 32'h114));
`else
    exec(32'h104, enc_b(13'd16, 5'd0, 5'd0, F3_BEQ), exp_ill(32'h104, 5'd0));
`endif
    drain("pre_reset");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_zero("reset_mid_flush");
    reset = 1'b0;
    exec(32'h300, enc_r(F7_BASE, 5'd2, 5'd1, F3_ADD, 5'd20),       exp_w(32'h300, 5'd20, 32'h0));
    exec(32'h304, enc_i(12'd0, 5'd15, F3_ADD, 5'd21, OPC_OP_IMM),  exp_w(32'h304, 5'd21, 32'h0));
    drain("post_reset");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_alu();
    test_illegal();
    test_branch();
    test_reset_flush();
    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
